// File: rtl/axi_aw_alloc_pkg.sv
// -----------------------------------------------------------------------------
// axi_aw_alloc_pkg
// Shared definitions for the AW QoS allocator:
//   - AW payload field widths and bit offsets (LSB first: addr, len, size,
//     burst, lock, cache, prot, region, user, spare, qos at the very top)
//   - aw_payload_w(): total payload width from address and user widths
//   - out_state_e: output-stage state encoding
//   - route_entry_t: route FIFO entry {bin, oh}, sized for up to 32 ports
// -----------------------------------------------------------------------------
package axi_aw_alloc_pkg;

    localparam int AW_LEN_W    = 8;
    localparam int AW_SIZE_W   = 3;
    localparam int AW_BURST_W  = 2;
    localparam int AW_LOCK_W   = 1;
    localparam int AW_CACHE_W  = 4;
    localparam int AW_PROT_W   = 3;
    localparam int AW_REGION_W = 4;
    localparam int AW_QOS_W    = 4;

    // Fixed (non addr/user) part of the payload. The named fields occupy 29
    // bits; the remaining 4 bits sit between user and qos and are carried
    // through untouched.
    localparam int AW_FIXED_W  = 33;

    localparam int ROUTE_MAX_PORTS = 32;
    localparam int ROUTE_MAX_LOG   = 5;

    function automatic int aw_payload_w(input int addr_w, input int user_w);
        return addr_w + user_w + AW_FIXED_W;
    endfunction

    function automatic int aw_len_lsb(input int addr_w);
        return addr_w;
    endfunction

    function automatic int aw_size_lsb(input int addr_w);
        return aw_len_lsb(addr_w) + AW_LEN_W;
    endfunction

    function automatic int aw_burst_lsb(input int addr_w);
        return aw_size_lsb(addr_w) + AW_SIZE_W;
    endfunction

    function automatic int aw_lock_lsb(input int addr_w);
        return aw_burst_lsb(addr_w) + AW_BURST_W;
    endfunction

    function automatic int aw_cache_lsb(input int addr_w);
        return aw_lock_lsb(addr_w) + AW_LOCK_W;
    endfunction

    function automatic int aw_prot_lsb(input int addr_w);
        return aw_cache_lsb(addr_w) + AW_CACHE_W;
    endfunction

    function automatic int aw_region_lsb(input int addr_w);
        return aw_prot_lsb(addr_w) + AW_PROT_W;
    endfunction

    function automatic int aw_user_lsb(input int addr_w);
        return aw_region_lsb(addr_w) + AW_REGION_W;
    endfunction

    // qos always occupies the top AW_QOS_W bits of the payload.
    function automatic int aw_qos_lsb(input int addr_w, input int user_w);
        return aw_payload_w(addr_w, user_w) - AW_QOS_W;
    endfunction

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    typedef struct packed {
        logic [ROUTE_MAX_LOG-1:0]   bin;
        logic [ROUTE_MAX_PORTS-1:0] oh;
    } route_entry_t;

endpackage

// File: rtl/axi_aw_route_fifo.sv
// -----------------------------------------------------------------------------
// axi_aw_route_fifo
// Synchronous FIFO holding the port route of every accepted AW, consumed by
// the W allocator one entry per burst. The head entry is registered, so an
// entry pushed at edge k is visible on dout from the cycle after edge k.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, din    write request and data (ignored when full without a pop)
//   pop          consume head (ignored when empty)
//   valid, dout  registered head entry and its valid flag
//   level        number of occupied entries (0..DEPTH)
// -----------------------------------------------------------------------------
module axi_aw_route_fifo #(
    parameter int WIDTH   = 10,
    parameter int DEPTH   = 8,
    parameter int PTR_W   = $clog2(DEPTH),
    parameter int LEVEL_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [WIDTH-1:0]   din,
    input  logic               pop,
    output logic               valid,
    output logic [WIDTH-1:0]   dout,
    output logic [LEVEL_W-1:0] level
);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_nxt;
    logic [LEVEL_W-1:0] level_q;
    logic               do_push;
    logic               do_pop;

    assign do_pop     = pop && (level_q != '0);
    // A pop in the same cycle frees the slot the push needs.
    assign do_push    = push && ((level_q != LEVEL_W'(DEPTH)) || do_pop);
    assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
    assign level      = level_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid    <= 1'b0;
            dout     <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_nxt;
            end

            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LEVEL_W'(1);
                2'b01:   level_q <= level_q - LEVEL_W'(1);
                default: level_q <= level_q;
            endcase

            // Head register: after a pop the next stored entry moves up; if
            // the FIFO was (or becomes) otherwise empty the pushed word goes
            // straight to the head.
            if (do_pop) begin
                if (level_q >= LEVEL_W'(2)) begin
                    dout  <= mem[rd_ptr_nxt];
                    valid <= 1'b1;
                end else if (do_push) begin
                    dout  <= din;
                    valid <= 1'b1;
                end else begin
                    dout  <= '0;
                    valid <= 1'b0;
                end
            end else if (do_push && (level_q == '0)) begin
                dout  <= din;
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_aw_qos_allocator.sv
// -----------------------------------------------------------------------------
// axi_aw_qos_allocator
// Arbitrates N_TARG_PORT slave-port AW requests onto one master AW channel
// (QoS-first round-robin), registers the winner in a one-entry output stage
// with its ID extended by the winner's port index, and records the winner in
// a route FIFO for the W allocator.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   awid_i, awpayload_i     per-port ID and AW fields (qos in the top 4 bits)
//   awvalid_i / awready_o   per-port request / one-hot (or zero) accept
//   awid_o, awpayload_o     registered {port index, id} and payload
//   awvalid_o / awready_i   master request / accept
//   w_route_valid_o         route FIFO head valid
//   w_route_oh_o/_bin_o     head entry port, one-hot and binary
//   w_route_pop_i           W allocator consumed the head entry
//   fifo_level_o            occupied route entries
// Handshake: a transfer happens on a channel in every cycle where valid and
// ready are both high; valid never waits on ready, and the output stage keeps
// awid_o/awpayload_o stable while awvalid_o is high until awready_i.
// Port count is limited to 32 by route_entry_t.
// -----------------------------------------------------------------------------
module axi_aw_qos_allocator
    import axi_aw_alloc_pkg::*;
#(
    parameter int N_TARG_PORT   = 7,
    parameter int LOG_N_TARG    = $clog2(N_TARG_PORT),
    parameter int AXI_ADDRESS_W = 32,
    parameter int AXI_USER_W    = 6,
    parameter int AXI_ID_IN     = 16,
    parameter int AXI_ID_OUT    = AXI_ID_IN + LOG_N_TARG,
    parameter int FIFO_DEPTH    = 8,
    parameter int QOS_EN        = 1,
    parameter int AW_PAYLOAD_W  = aw_payload_w(AXI_ADDRESS_W, AXI_USER_W),
    parameter int LEVEL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [N_TARG_PORT-1:0][AXI_ID_IN-1:0]    awid_i,
    input  logic [N_TARG_PORT-1:0][AW_PAYLOAD_W-1:0] awpayload_i,
    input  logic [N_TARG_PORT-1:0]                   awvalid_i,
    output logic [N_TARG_PORT-1:0]                   awready_o,
    output logic [AXI_ID_OUT-1:0]                    awid_o,
    output logic [AW_PAYLOAD_W-1:0]                  awpayload_o,
    output logic                                     awvalid_o,
    input  logic                                     awready_i,
    output logic                                     w_route_valid_o,
    output logic [N_TARG_PORT-1:0]                   w_route_oh_o,
    output logic [LOG_N_TARG-1:0]                    w_route_bin_o,
    input  logic                                     w_route_pop_i,
    output logic [LEVEL_W-1:0]                       fifo_level_o
);

    localparam int QOS_LSB = aw_qos_lsb(AXI_ADDRESS_W, AXI_USER_W);
    localparam int ROUTE_W = LOG_N_TARG + N_TARG_PORT;

    out_state_e               state_q;
    out_state_e               state_d;
    logic [LOG_N_TARG-1:0]    rr_ptr_q;

    logic [AW_QOS_W-1:0]      max_qos;
    logic [N_TARG_PORT-1:0]   cand;
    logic [LOG_N_TARG:0]      scan_idx;
    logic                     found;
    logic [LOG_N_TARG-1:0]    win_idx;
    logic [N_TARG_PORT-1:0]   win_oh;

    logic                     route_space;
    logic                     capture_ok;
    logic                     capture;

    route_entry_t             win_route;
    logic [ROUTE_W-1:0]       route_din;
    logic [ROUTE_W-1:0]       route_head;
    logic                     route_pad_unused;

    // ---------------- winner selection ----------------
    always_comb begin
        max_qos = '0;
        for (int i = 0; i < N_TARG_PORT; i++) begin
            if (awvalid_i[i] && (awpayload_i[i][QOS_LSB +: AW_QOS_W] > max_qos)) begin
                max_qos = awpayload_i[i][QOS_LSB +: AW_QOS_W];
            end
        end

        for (int i = 0; i < N_TARG_PORT; i++) begin
            cand[i] = awvalid_i[i] &&
                      ((QOS_EN == 0) || (awpayload_i[i][QOS_LSB +: AW_QOS_W] == max_qos));
        end

        // Scan rr_ptr+1 .. rr_ptr+N (mod N); the first candidate wins, so the
        // last winner has lowest priority among equals.
        found    = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        for (int k = 1; k <= N_TARG_PORT; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (LOG_N_TARG + 1)'(k);
            if (scan_idx >= (LOG_N_TARG + 1)'(N_TARG_PORT)) begin
                scan_idx = scan_idx - (LOG_N_TARG + 1)'(N_TARG_PORT);
            end
            if (!found && cand[scan_idx[LOG_N_TARG-1:0]]) begin
                found   = 1'b1;
                win_idx = scan_idx[LOG_N_TARG-1:0];
            end
        end
    end

    assign win_oh = {{(N_TARG_PORT-1){1'b0}}, 1'b1} << win_idx;

    // Capture decision uses the current state only, so awready_o never
    // depends on the output stage's next state. Held low during reset.
    assign route_space = (fifo_level_o < LEVEL_W'(FIFO_DEPTH)) || w_route_pop_i;
    assign capture_ok  = rst_n && ((state_q == OUT_EMPTY) || awready_i) && route_space;
    assign capture     = capture_ok && (|awvalid_i);
    assign awready_o   = capture ? win_oh : '0;

    // ---------------- output stage FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OUT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            OUT_EMPTY: begin
                if (capture) begin
                    state_d = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (capture) begin
                    state_d = OUT_FULL;
                end else if (awready_i) begin
                    state_d = OUT_EMPTY;
                end
            end
            default: state_d = OUT_EMPTY;
        endcase
    end

    always_comb begin
        awvalid_o = (state_q == OUT_FULL);
    end

    // Output data and round-robin pointer only move on capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awid_o      <= '0;
            awpayload_o <= '0;
            rr_ptr_q    <= LOG_N_TARG'(N_TARG_PORT - 1);
        end else if (capture) begin
            awid_o      <= {win_idx, awid_i[win_idx]};
            awpayload_o <= awpayload_i[win_idx];
            rr_ptr_q    <= win_idx;
        end
    end

    // ---------------- route FIFO ----------------
    always_comb begin
        win_route     = '0;
        win_route.bin = ROUTE_MAX_LOG'(win_idx);
        win_route.oh  = ROUTE_MAX_PORTS'(win_oh);
    end

    assign route_din        = {win_route.bin[LOG_N_TARG-1:0], win_route.oh[N_TARG_PORT-1:0]};
    // Upper struct bits beyond this configuration are always zero.
    assign route_pad_unused = ^win_route;

    axi_aw_route_fifo #(
        .WIDTH   (ROUTE_W),
        .DEPTH   (FIFO_DEPTH),
        .PTR_W   ($clog2(FIFO_DEPTH)),
        .LEVEL_W (LEVEL_W)
    ) u_route_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (capture),
        .din   (route_din),
        .pop   (w_route_pop_i),
        .valid (w_route_valid_o),
        .dout  (route_head),
        .level (fifo_level_o)
    );

    assign w_route_bin_o = route_head[ROUTE_W-1 -: LOG_N_TARG];
    assign w_route_oh_o  = route_head[N_TARG_PORT-1:0];

endmodule
